// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, converter states and double-dabble step for display_ctrl
package display_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CONV_A,
    CONV_B,
    COMMIT
  } conv_state_e;

  // One double-dabble iteration: correct nibbles >= 5, then shift the next binary bit in.
  // The hundreds nibble never exceeds 2 for 8-bit inputs, so the MSB lost by the shift is always 0.
  function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end
    end
    return {adj[10:0], bit_in};
  endfunction

endpackage

// File: rtl/bcd_decode7.sv
// rtl/bcd_decode7.sv - combinational BCD nibble to active-low 7-segment decoder
module bcd_decode7
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_ctrl.sv
// rtl/display_ctrl.sv - six-digit multiplexed 7-segment driver with sequential BCD conversion
// Optional leading-zero blanking per 3-digit group when DISPLAY_LZB_EN is defined.
module display_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable_displays,
  input  logic [7:0] number_a,
  input  logic [7:0] number_b,
  output logic [5:0] digit_an,
  output logic [6:0] seg
);

  localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  conv_state_e      state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shadow_a_q, shadow_a_d;
  logic [7:0]       shadow_b_q, shadow_b_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [11:0]      res_a_q, res_a_d;
  logic [23:0]      digits_q, digits_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       digit_an_q, digit_an_d;
  logic [6:0]       seg_q, seg_d;

  logic        dd_bit;
  logic [11:0] dd_next;
  logic [3:0]  cur_digit;
  logic        lz_blank;
  logic [3:0]  dec_in;
  logic [6:0]  dec_seg;

  // The single double-dabble engine is fed from whichever shadow is being converted
  assign dd_bit  = (state_q == CONV_A) ? shadow_a_q[7] : shadow_b_q[7];
  assign dd_next = dd_step(bcd_q, dd_bit);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    bcd_d      = bcd_q;
    res_a_d    = res_a_q;
    digits_d   = digits_q;
    case (state_q)
      IDLE: begin
        shadow_a_d = number_a;
        shadow_b_d = number_b;
        bcd_d      = '0;
        bit_cnt_d  = '0;
        state_d    = CONV_A;
      end
      CONV_A: begin
        bcd_d      = dd_next;
        shadow_a_d = shadow_a_q << 1;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          res_a_d = dd_next;
          bcd_d   = '0;
          state_d = CONV_B;
        end
      end
      CONV_B: begin
        bcd_d      = dd_next;
        shadow_b_d = shadow_b_q << 1;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        digits_d = {res_a_q, bcd_q};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == CNT_LAST) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    cur_digit = digits_q[3:0];
    case (idx_q)
      3'd1:    cur_digit = digits_q[7:4];
      3'd2:    cur_digit = digits_q[11:8];
      3'd3:    cur_digit = digits_q[15:12];
      3'd4:    cur_digit = digits_q[19:16];
      3'd5:    cur_digit = digits_q[23:20];
      default: cur_digit = digits_q[3:0];
    endcase
  end

`ifdef DISPLAY_LZB_EN
  // Hundreds blank on zero; tens blank only when the hundreds above it is also zero
  always_comb begin
    lz_blank = 1'b0;
    case (idx_q)
      3'd5:    lz_blank = (digits_q[23:20] == 4'd0);
      3'd4:    lz_blank = (digits_q[23:16] == 8'd0);
      3'd2:    lz_blank = (digits_q[11:8] == 4'd0);
      3'd1:    lz_blank = (digits_q[11:4] == 8'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // 4'hF is outside 0..9, so the decoder renders it blank
  assign dec_in = lz_blank ? 4'hF : cur_digit;

  bcd_decode7 u_decode (
    .digit_i (dec_in),
    .seg_o   (dec_seg)
  );

  always_comb begin
    digit_an_d = '1;
    seg_d      = SEG_BLANK;
    if (enable_displays) begin
      digit_an_d = ~(6'b000001 << idx_q);
      seg_d      = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      bcd_q      <= '0;
      res_a_q    <= '0;
      digits_q   <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      digit_an_q <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      bcd_q      <= bcd_d;
      res_a_q    <= res_a_d;
      digits_q   <= digits_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      digit_an_q <= digit_an_d;
      seg_q      <= seg_d;
    end
  end

  assign digit_an = digit_an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_display_ctrl.sv
// tb/tb_display_ctrl.sv - randomized self-checking bench for display_ctrl against a decimal-digit model
module tb_display_ctrl;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [7:0] na;
  logic [7:0] nb;
  logic [5:0] digit_an;
  logic [6:0] seg;

  int n_pass  = 0;
  int n_total = 0;

  // Model: k counts clock edges since reset release; inputs are captured once per 18-cycle loop
  // and become visible after that loop completes.
  int         k      = 0;
  int         cap_a  = 0;
  int         cap_b  = 0;
  int         disp_a = 0;
  int         disp_b = 0;
  logic [5:0] exp_an;
  logic [6:0] exp_seg;

  always #5 clk = ~clk;

  display_ctrl #(.REFRESH_DIV(R)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .enable_displays (en),
    .number_a        (na),
    .number_b        (nb),
    .digit_an        (digit_an),
    .seg             (seg)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int idx, input int va, input int vb);
    int v;
    int pos;
    int d;
    v   = (idx >= 3) ? va : vb;
    pos = idx % 3;
    d   = (pos == 0) ? (v % 10) : (pos == 1) ? ((v / 10) % 10) : ((v / 100) % 10);
`ifdef DISPLAY_LZB_EN
    if (pos == 2 && v < 100) return 7'b1111111;
    if (pos == 1 && v < 10) return 7'b1111111;
`endif
    return seg_of(d);
  endfunction

  function automatic int cur_idx();
    return ((k - 1) / R) % 6;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rstn) begin
      k       = 0;
      disp_a  = 0;
      disp_b  = 0;
      exp_an  = 6'b111111;
      exp_seg = 7'b1111111;
    end else begin
      k = k + 1;
      if (k > 1 && (k - 1) % 18 == 0) begin
        disp_a = cap_a;
        disp_b = cap_b;
      end
      if (!en) begin
        exp_an  = 6'b111111;
        exp_seg = 7'b1111111;
      end else begin
        exp_an  = ~(6'b000001 << cur_idx());
        exp_seg = model_seg(cur_idx(), disp_a, disp_b);
      end
      if (k % 18 == 1) begin
        cap_a = int'(na);
        cap_b = int'(nb);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b1;
    na   = 8'd0;
    nb   = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (digit_an !== 6'b111111) $display("FAIL reset_an: got %b want 111111", digit_an);
      else n_pass++;
      n_total++;
      if (seg !== 7'b1111111) $display("FAIL reset_seg: got %b want 1111111", seg);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    rstn = 1'b1;
    for (int i = 0; i < 12 * R; i++) begin
      tick();
      n_total++;
      if (digit_an !== exp_an) $display("FAIL scan_an k=%0d: got %b want %b", k, digit_an, exp_an);
      else n_pass++;
      n_total++;
      if (seg !== 7'b1000000) $display("FAIL scan_seg k=%0d: got %b want 1000000", k, seg);
      else n_pass++;
    end
  endtask

  task automatic test_convert();
    for (int p = 0; p < 5; p++) begin
      na = (p == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      nb = (p == 0) ? 8'd128 : 8'($urandom_range(0, 255));
      for (int i = 0; i < 60; i++) begin
        tick();
        n_total++;
        if (digit_an !== exp_an) $display("FAIL conv_an a=%0d b=%0d k=%0d: got %b want %b", na, nb, k, digit_an, exp_an);
        else n_pass++;
        n_total++;
        if (seg !== exp_seg) $display("FAIL conv_seg a=%0d b=%0d k=%0d: got %b want %b", na, nb, k, seg, exp_seg);
        else n_pass++;
      end
      if (p == 0) begin
        for (int i = 0; i < 6 * R && cur_idx() != 2; i++) tick();
        n_total++;
        if (seg !== 7'b1111001) $display("FAIL conv_idx2_seg: got %b want 1111001", seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_change();
    nb = 8'd99;
    for (int i = 0; i < 40; i++) tick();
    for (int i = 0; i < 18 && (k % 18) != 12; i++) tick();
    nb = 8'd100;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_total++;
      if (digit_an !== exp_an) $display("FAIL mid_an k=%0d: got %b want %b", k, digit_an, exp_an);
      else n_pass++;
      n_total++;
      if (seg !== exp_seg) $display("FAIL mid_seg k=%0d idx=%0d: got %b want %b", k, cur_idx(), seg, exp_seg);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    int drop_k;
    for (int i = 0; i < 6 * R && !(cur_idx() == 3 && ((k - 1) % R) == 0); i++) tick();
    drop_k = k;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if (digit_an !== 6'b111111 || seg !== 7'b1111111)
        $display("FAIL enable_off k=%0d: got an=%b seg=%b want 111111/1111111", k, digit_an, seg);
      else n_pass++;
    end
    en = 1'b1;
    tick();
    n_total++;
    if (digit_an !== ~(6'b000001 << ((3 + (k - drop_k - 1) / R) % 6)))
      $display("FAIL enable_resume_idx: got %b want %b", digit_an, ~(6'b000001 << ((3 + (k - drop_k - 1) / R) % 6)));
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_total++;
      if (digit_an !== exp_an || seg !== exp_seg)
        $display("FAIL enable_on k=%0d: got an=%b seg=%b want %b/%b", k, digit_an, seg, exp_an, exp_seg);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midconv();
    na = 8'd200;
    for (int i = 0; i < 40; i++) tick();
    for (int i = 0; i < 18 && (k % 18) != 4; i++) tick();
    rstn = 1'b0;
    tick();
    n_total++;
    if (digit_an !== 6'b111111 || seg !== 7'b1111111)
      $display("FAIL rst_mid: got an=%b seg=%b want 111111/1111111", digit_an, seg);
    else n_pass++;
    rstn = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      n_total++;
      if (digit_an !== exp_an || seg !== exp_seg)
        $display("FAIL rst_recover k=%0d: got an=%b seg=%b want %b/%b", k, digit_an, seg, exp_an, exp_seg);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) na = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) nb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) en = ~en;
      tick();
      n_total++;
      if (digit_an !== exp_an || seg !== exp_seg)
        $display("FAIL b2b k=%0d: got an=%b seg=%b want %b/%b", k, digit_an, seg, exp_an, exp_seg);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert();
    test_mid_change();
    test_enable();
    test_reset_midconv();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
